// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for the highway/farm-road traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_t;

    typedef enum logic [2:0] {
        S_HG = 3'd0,
        S_HY = 3'd1,
        S_FG = 3'd2,
        S_FY = 3'd3,
        S_EY = 3'd4,
        S_EG = 3'd5
    } state_t;

    // Emergency context captured on entry: the road to turn green, and which road shows yellow in EY.
    typedef struct packed {
        logic dir;
        logic ey_farm;
    } emg_ctx_t;

    function automatic logic is_normal(state_t s);
        return s inside {S_HG, S_HY, S_FG, S_FY};
    endfunction

    function automatic logic farm_active(state_t s);
        return s inside {S_FG, S_FY};
    endfunction

    // Skip the yellow phase only when the requested road is already green.
    function automatic state_t emg_entry(state_t s, logic dir);
        if ((s == S_HG && !dir) || (s == S_FG && dir))
            return S_EG;
        return S_EY;
    endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Decodes controller state plus latched emergency context into highway/farm lamp codes.
module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  state_t   state,
    input  emg_ctx_t ctx,
    output lamp_t    hl,
    output lamp_t    fl
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        hl = RED;
        fl = RED;
        case (state)
            S_HG: hl = GREEN;
            S_HY: hl = YELLOW;
            S_FG: fl = GREEN;
            S_FY: fl = YELLOW;
            S_EY: if (ctx.ey_farm) fl = YELLOW; else hl = YELLOW;
            S_EG: if (ctx.dir) fl = GREEN; else hl = GREEN;
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Highway/farm-road traffic light Moore FSM with timer-restart output.
// Emergency pre-emption is compiled in only when TRAFFIC_CTRL_EMERGENCY_EN is defined.
module traffic_ctrl
    import traffic_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       C,
    input  logic       TS,
    input  logic       TL,
    input  logic       EMG,
    input  logic       EMG_DIR,
    output logic       ST,
    output logic [1:0] HL,
    output logic [1:0] FL,
    output logic       EMG_ACK
);

    state_t   state, state_next;
    emg_ctx_t ctx, ctx_next;
    logic     emg_req, emg_dir_in;
    logic     ts_ok, tl_ok;
    lamp_t    hl_lamp, fl_lamp;

`ifdef TRAFFIC_CTRL_EMERGENCY_EN
    assign emg_req    = EMG;
    assign emg_dir_in = EMG_DIR;
    assign EMG_ACK    = (state == S_EG);
`else
    logic unused_emg;
    assign unused_emg = EMG ^ EMG_DIR;
    assign emg_req    = 1'b0;
    assign emg_dir_in = 1'b0;
    assign EMG_ACK    = 1'b0;
`endif

    // The timer count is stale during the restart cycle, so its flags are masked then.
    assign ts_ok = TS & ~ST;
    assign tl_ok = TL & ~ST;

    always_ff @(posedge Clk) begin
        // NOTE: synchronous reset; ST is forced high so the timer stays cleared through reset.
        if (Rst) begin
            state <= S_HG;
            ctx   <= '0;
            ST    <= 1'b1;
        end else begin
            state <= state_next;
            ctx   <= ctx_next;
            ST    <= (state_next != state);
        end
    end

    always_comb begin
        state_next = state;
        ctx_next   = ctx;
        if (emg_req && is_normal(state)) begin
            ctx_next.dir     = emg_dir_in;
            ctx_next.ey_farm = farm_active(state);
            state_next       = emg_entry(state, emg_dir_in);
        end else begin
            case (state)
                S_HG:    if (C && tl_ok) state_next = S_HY;
                S_HY:    if (ts_ok) state_next = S_FG;
                S_FG:    if (!ST && (!C || TL)) state_next = S_FY;
                S_FY:    if (ts_ok) state_next = S_HG;
                S_EY:    if (ts_ok) state_next = S_EG;
                S_EG:    if (!emg_req && ts_ok) state_next = ctx.dir ? S_FG : S_HG;
                default: state_next = S_HG;
            endcase
        end
    end

    traffic_lamp_decode u_lamp_decode (
        .state (state),
        .ctx   (ctx),
        .hl    (hl_lamp),
        .fl    (fl_lamp)
    );

    assign HL = hl_lamp;
    assign FL = fl_lamp;

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
- Parameters: none.
- REQ-001: Clk  input  1  single system clock; all state updates on posedge Clk.
- REQ-002: Rst  input  1  synchronous, active-high reset.
- REQ-003: C  input  1  farm-road car sensor, already synchronous to Clk.
- REQ-004: TS  input  1  short-interval-elapsed flag from the interval timer.
- REQ-005: TL  input  1  long-interval-elapsed flag from the interval timer.
- REQ-006: EMG  input  1  emergency-vehicle request, level, synchronous to Clk.
- REQ-007: EMG_DIR  input  1  emergency road: 0 = highway, 1 = farm.
- REQ-008: ST  output  1  timer restart; registered, drives the timer's ST.
- REQ-009: HL  output  2  highway lamp: GREEN=2'b00, YELLOW=2'b01, RED=2'b10.
- REQ-010: FL  output  2  farm lamp, same encoding as HL.
- REQ-011: EMG_ACK  output  1  high while emergency green is shown.

Function
- REQ-012: The block SHALL be a Moore FSM with states HG, HY, FG, FY, EY, EG; HL/FL SHALL be decoded from the state register only.
- REQ-013: Lamps: HG=HL GREEN/FL RED; HY=YELLOW/RED; FG=RED/GREEN; FY=RED/YELLOW; EG=GREEN on latched road, RED on the other; EY=YELLOW on the road green/yellow at entry, RED on the other.
- REQ-014: ST SHALL be 1 for exactly the one cycle after every state-register change, else 0.
- REQ-015: While ST=1, TS and TL SHALL be ignored (stale count) and no TS/TL-driven transition SHALL occur.
- REQ-016: HG->HY when C=1 and TL=1; HY->FG when TS=1; FG->FY when C=0 or TL=1; FY->HG when TS=1.
- REQ-017: EMG entry (EMERGENCY_EN only), priority over all normal transitions in the same cycle: EMG_DIR SHALL be latched; HG with dir 0 or FG with dir 1 -> EG directly; HG with dir 1, FG with dir 0, HY or FY -> EY.
- REQ-018: EY->EG when TS=1 (subject to REQ-015).
- REQ-019: EG held while EMG=1; EG exits when EMG=0 and TS=1, to HG if latched dir 0, to FG if latched dir 1.
- REQ-020: EMG_DIR changes and EMG re-assertion during EY/EG SHALL be ignored; the latched direction is retained until exit from EG.
- REQ-021: EMG_ACK SHALL equal 1 exactly when state is EG.
- REQ-022: An unreachable state encoding SHALL recover to HG with ST=1 on the next cycle.

Reset
- REQ-023: With Rst=1 at posedge Clk: state=HG, ST=1, latched dir=0; thus HL=GREEN, FL=RED, EMG_ACK=0.
- REQ-024: ST=1 during reset SHALL hold the external timer cleared; the first cycle after release counts as the post-transition ST cycle.
- REQ-025: Reset mid-emergency SHALL abandon EY/EG immediately with no yellow phase.

Configuration
- REQ-026: Macro TRAFFIC_CTRL_EMERGENCY_EN defined: REQ-017..REQ-021 active.
- REQ-027: Macro undefined: EMG and EMG_DIR ports present but ignored, EY/EG unreachable, EMG_ACK tied 0, normal FSM unchanged.

Structure
- REQ-028: Shared package traffic_pkg SHALL hold the state encoding and the lamp codes GREEN/YELLOW/RED, shared with the top-level integration.
- REQ-029: One sub-module, traffic_lamp_decode (state plus latched dir -> HL/FL), SHALL be used; the timer remains a sibling instance.

Verification (bench instantiates the existing timer with TIME_SMALL=2, TIME_LONG=4)
- REQ-030: Reset release, C=1 held -> HY entered at 6th posedge after release; HY lasts 4 cycles; then FG; ST pulses 1 cycle at each change.
- REQ-031: C=0 held for 50 cycles -> state stays HG, ST stays 0 after the first post-reset cycle.
- REQ-032: In FG, drop C -> FY next TS-eligible cycle, then HG after TS; lamps match REQ-013 every cycle.
- REQ-033: In HG, EMG=1, EMG_DIR=1 -> EY (HL YELLOW), then EG (FL GREEN, EMG_ACK=1); toggle EMG_DIR in EG -> no change; EMG=0 -> FG after TS.
- REQ-034: EMG=1 and C/TL transition condition in the same cycle -> emergency path wins; Rst during EG -> HG, ST=1, EMG_ACK=0 next cycle.
- REQ-035: Build without TRAFFIC_CTRL_EMERGENCY_EN -> EMG pulses have no effect, EMG_ACK constantly 0.
